reg_dump_reader: RTL

Debug/readout engine on the register file's inspection port: on a start pulse it walks the register index from 0 to NUM_REGS-1. For each register it drives `regNo`, captures the returned `val`, and emits it as one beat on a valid/ready output stream. It sits between the CPU register file and the testbench or host-side debug logic. It replaces ad-hoc probing of single registers with an ordered, back-pressurable dump of the whole file.

---
 rtl/reg_dump_pkg.sv | 16 +
 rtl/reg_dump_csum.sv | 30 +++
 rtl/reg_dump_reader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register dump engine: state encodings and default geometry.
package reg_dump_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int IDX_W_DEF    = 5;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LOAD = 3'd1;
  localparam state_t ST_SEND = 3'd2;
  localparam state_t ST_CSUM = 3'd3;
  localparam state_t ST_DONE = 3'd4;

endpackage

// File: rtl/reg_dump_csum.sv
// XOR accumulator over every register value captured during a dump.
// Clear takes priority over enable so a new dump always starts from zero.
module reg_dump_csum
  import reg_dump_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_csum
);

  logic [DATA_W-1:0] r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_enable) begin
      r_acc <= r_acc ^ i_data;
    end
  end

  assign o_csum = r_acc;

endmodule

// File: rtl/reg_dump_reader.sv
// Walks regNo over 0..NUM_REGS-1 and streams each captured value on a valid/ready port.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum beat after the last register.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int IDX_W    = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              startin,
  input  logic              start,
  output logic [IDX_W-1:0]  regNo,
  input  logic [DATA_W-1:0] val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_counter;
  logic [IDX_W-1:0]   r_outIndex;
  logic [DATA_W-1:0]  r_outData;
  logic               r_outLast;
  logic               w_accept;
  logic               w_atLast;

  assign w_accept = (r_state == ST_SEND) && out_ready;
  assign w_atLast = (r_counter == LAST_IDX);

`ifdef REG_DUMP_CHECKSUM_EN
  logic              r_csumPhase;
  logic [DATA_W-1:0] w_csum;

  // Each register is folded in at the same edge its value is captured for the stream.
  reg_dump_csum #(.DATA_W(DATA_W)) u_csum (
    .clk      (clk),
    .rst      (startin),
    .i_clear  ((r_state == ST_IDLE) && start),
    .i_enable (r_state == ST_LOAD),
    .i_data   (val),
    .o_csum   (w_csum)
  );
`endif

  always_ff @(posedge clk or posedge startin) begin
    if (startin) begin
      r_state    <= ST_IDLE;
      r_counter  <= '0;
      r_outIndex <= '0;
      r_outData  <= '0;
      r_outLast  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      r_csumPhase <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_counter <= '0;
            r_state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_outData  <= val;
          r_outIndex <= r_counter;
`ifdef REG_DUMP_CHECKSUM_EN
          r_outLast  <= 1'b0;
`else
          r_outLast  <= w_atLast;
`endif
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          if (w_accept) begin
`ifdef REG_DUMP_CHECKSUM_EN
            if (r_csumPhase) begin
              r_state <= ST_DONE;
            end else if (w_atLast) begin
              r_state <= ST_CSUM;
            end else begin
              r_counter <= r_counter + IDX_W'(1);
              r_state   <= ST_LOAD;
            end
`else
            if (w_atLast) begin
              r_state <= ST_DONE;
            end else begin
              r_counter <= r_counter + IDX_W'(1);
              r_state   <= ST_LOAD;
            end
`endif
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        // The checksum beat is loaded like a register beat, then reuses SEND for the handshake.
        ST_CSUM: begin
          r_outData   <= w_csum;
          r_outIndex  <= '0;
          r_outLast   <= 1'b1;
          r_csumPhase <= 1'b1;
          r_state     <= ST_SEND;
        end
`endif
        ST_DONE: begin
          r_counter <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
          r_csumPhase <= 1'b0;
`endif
          r_state   <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign regNo     = r_counter;
  assign out_valid = (r_state == ST_SEND);
  assign out_index = r_outIndex;
  assign out_data  = r_outData;
  assign out_last  = r_outLast && out_valid;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);

endmodule
